// File: rtl/manchester_rx_ctrl.sv
// Manchester receive controller: times line edges against the half-bit reference,
// hunts for the preamble, locks on start-of-frame and hands decoded words downstream.
module manchester_rx_ctrl #(
  parameter int CNT_W        = 6,
  parameter int PREAMBLE_LEN = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 globalRest,
  input  logic                 enable,
  input  logic [3:0]           REF,
  input  logic                 reCLK,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 locked,
  output logic                 err,
  output logic [1:0]           dbgState
);

  // Handshake: a word transfers on any rising clk edge where rx_valid and rx_ready
  // are both high; rx_valid/rx_data stay stable until that transfer happens.

  localparam int EW    = CNT_W + 3;
  localparam int RUN_W = $clog2(PREAMBLE_LEN + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  logic                 s1, s2, s3;
  logic [CNT_W-1:0]     cnt;
  logic [RUN_W-1:0]     run;
  logic [BIT_W-1:0]     bitCnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 phase;

  logic                 edgeDet, dir;
  logic [EW-1:0]        iv2, cnt2, h1, h3, h5;
  logic                 isShort, isLong, isBad, timeout;
  logic                 sof, take, wordDone;
  logic [BIT_W-1:0]     nextBitCnt;
  logic [DATA_BITS-1:0] shiftIn;

  assign edgeDet = s2 ^ s3;
  assign dir     = s2;

  // All classification is done on doubled intervals so no division is needed.
  assign cnt2 = EW'(cnt) << 1;
  assign iv2  = (EW'(cnt) + EW'(1)) << 1;
  assign h1   = EW'(REF);
  assign h3   = h1 + (h1 << 1);
  assign h5   = h1 + (h1 << 2);

  assign isShort = edgeDet && (iv2 >= h1) && (iv2 < h3);
  assign isLong  = edgeDet && (iv2 >= h3) && (iv2 < h5);
  // The window is one count wide, so the timeout fires exactly once per silent gap.
  assign timeout = !edgeDet && (cnt2 >= h5) && (cnt2 < h5 + EW'(2));
  assign isBad   = (edgeDet && !isShort && !isLong) || timeout;

  assign sof        = (state == HUNT) && isLong && (run == RUN_W'(PREAMBLE_LEN));
  assign take       = enable && (sof || ((state == DATA) &&
                      ((isShort && !phase) || (isLong && phase))));
  assign nextBitCnt = bitCnt + BIT_W'(1);
  assign wordDone   = take && (nextBitCnt == BIT_W'(DATA_BITS));
  assign shiftIn    = {dir, shreg[DATA_BITS-1:1]};

  assign dbgState = state;

  always_ff @(posedge clk or posedge globalRest) begin
    if (globalRest) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      cnt      <= '0;
      run      <= '0;
      bitCnt   <= '0;
      shreg    <= '0;
      phase    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      s1  <= reCLK;
      s2  <= s1;
      s3  <= s2;
      err <= 1'b0;
      if (edgeDet)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);

      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (!enable) begin
        state  <= IDLE;
        run    <= '0;
        bitCnt <= '0;
        shreg  <= '0;
        phase  <= 1'b0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (isShort) begin
              if (run != RUN_W'(PREAMBLE_LEN))
                run <= run + RUN_W'(1);
            end else if (sof) begin
              state  <= DATA;
              locked <= 1'b1;
              phase  <= 1'b1;
              run    <= '0;
            end else if (isLong || isBad) begin
              run <= '0;
            end
          end
          DATA: begin
            if (isShort) begin
              phase <= ~phase;
            end else if ((isLong && !phase) || isBad) begin
              // End of frame is only clean on a word boundary.
              err    <= (isLong && !phase) || (bitCnt != '0);
              state  <= HUNT;
              locked <= 1'b0;
              run    <= '0;
              bitCnt <= '0;
              shreg  <= '0;
              phase  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (take) begin
        shreg <= shiftIn;
        if (wordDone) begin
          bitCnt <= '0;
          if (rx_valid && !rx_ready) begin
            err <= 1'b1;
          end else begin
            rx_data  <= shiftIn;
            rx_valid <= 1'b1;
          end
        end else begin
          bitCnt <= nextBitCnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_manchester_rx_ctrl.sv
// Directed bench for manchester_rx_ctrl: builds Manchester line waveforms at REF=8
// and scores delivered words against an expected queue.
module tb_manchester_rx_ctrl;

  logic       clk = 1'b0;
  logic       globalRest;
  logic       enable;
  logic [3:0] REF;
  logic       reCLK;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       locked;
  logic       err;
  logic [1:0] dbgState;

  int   vectors     = 0;
  int   miscompares = 0;
  int   errCount    = 0;
  int   validCycles = 0;
  logic sawLocked   = 1'b0;
  int   errBase, validBase;

  logic [7:0] exp_q[$];
  logic [7:0] expWord;

  always #5 clk = ~clk;

  manchester_rx_ctrl dut (
    .clk        (clk),
    .globalRest (globalRest),
    .enable     (enable),
    .REF        (REF),
    .reCLK      (reCLK),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .locked     (locked),
    .err        (err),
    .dbgState   (dbgState)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lineSeg(input logic lvl, input int n);
    reCLK = lvl;
    waitClk(n);
  endtask

  // nShort SHORT intervals, a LONG gap, then the start-of-frame edge carrying bit 0.
  task automatic sendPreamble(input int nShort, input logic b0);
    logic lvl;
    lvl = (nShort % 2 == 0) ? ~b0 : b0;
    lineSeg(~lvl, 30);
    for (int i = 0; i <= nShort; i++) begin
      lineSeg(lvl, (i == nShort) ? 16 : 8);
      lvl = ~lvl;
    end
    lineSeg(b0, 8);
  endtask

  task automatic sendBits(input logic [7:0] w, input int first);
    for (int i = first; i < 8; i++) begin
      lineSeg(~w[i], 8);
      lineSeg(w[i], 8);
    end
  endtask

  task automatic sendFrame(input logic [7:0] w);
    sendPreamble(8, w[0]);
    sendBits(w, 1);
    lineSeg(w[7], 30);
  endtask

  // Output monitor: counts activity and scores every accepted word.
  always @(negedge clk) begin
    if (!globalRest) begin
      if (err) errCount++;
      if (rx_valid) validCycles++;
      if (locked) sawLocked = 1'b1;
      if (rx_valid && rx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_word: observed %0h expected none", rx_data);
        end else begin
          expWord = exp_q.pop_front();
          assert (rx_data === expWord) else begin
            miscompares++;
            $error("FAIL word: observed %0h expected %0h", rx_data, expWord);
          end
        end
      end
    end
  end

  initial begin
    globalRest = 1'b1;
    enable     = 1'b0;
    REF        = 4'd8;
    reCLK      = 1'b0;
    rx_ready   = 1'b0;
    waitClk(2);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_state", dbgState, 0);
    globalRest = 1'b0;
    waitClk(2);
    check("disabled_idle", dbgState, 0);
    enable = 1'b1;
    waitClk(2);
    check("enter_hunt", dbgState, 1);

    // Nominal frame
    rx_ready  = 1'b1;
    errBase   = errCount;
    validBase = validCycles;
    sawLocked = 1'b0;
    exp_q.push_back(8'hA5);
    sendFrame(8'hA5);
    check("nom_locked_seen", sawLocked, 1);
    check("nom_valid_cycles", validCycles - validBase, 1);
    check("nom_no_err", errCount - errBase, 0);
    check("nom_queue_empty", exp_q.size(), 0);
    check("eof_hunt", dbgState, 1);
    check("eof_unlocked", locked, 0);

    // Short preamble
    sawLocked = 1'b0;
    validBase = validCycles;
    errBase   = errCount;
    sendPreamble(7, 1'b1);
    lineSeg(1'b1, 30);
    check("shortpre_no_lock", sawLocked, 0);
    check("shortpre_no_valid", validCycles - validBase, 0);
    check("shortpre_no_err", errCount - errBase, 0);

    // Mid-word error after three data bits (1,0,1)
    errBase   = errCount;
    validBase = validCycles;
    sendPreamble(8, 1'b1);
    lineSeg(1'b1, 8);
    lineSeg(1'b0, 8);
    lineSeg(1'b0, 8);
    lineSeg(1'b1, 3);
    check("midword_locked", locked, 1);
    lineSeg(1'b0, 30);
    check("midword_err_pulse", errCount - errBase, 1);
    check("midword_unlocked", locked, 0);
    check("midword_no_valid", validCycles - validBase, 0);
    check("midword_hunt", dbgState, 1);

    errBase   = errCount;
    validBase = validCycles;
    exp_q.push_back(8'h3C);
    sendFrame(8'h3C);
    check("recover_valid_cycles", validCycles - validBase, 1);
    check("recover_queue_empty", exp_q.size(), 0);
    check("recover_no_err", errCount - errBase, 0);

    // Overrun: second word arrives while the first is still pending
    rx_ready = 1'b0;
    errBase  = errCount;
    exp_q.push_back(8'h11);
    sendPreamble(8, 1'b1);
    sendBits(8'h11, 1);
    sendBits(8'h22, 0);
    lineSeg(1'b0, 30);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_err_pulse", errCount - errBase, 1);
    rx_ready = 1'b1;
    waitClk(1);
    rx_ready = 1'b0;
    check("ovr_valid_cleared", rx_valid, 0);
    check("ovr_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a word
    sendPreamble(8, 1'b1);
    lineSeg(1'b0, 8);
    lineSeg(1'b1, 4);
    check("prereset_locked", locked, 1);
    #2 globalRest = 1'b1;
    #1;
    check("arst_rx_data", rx_data, 0);
    check("arst_rx_valid", rx_valid, 0);
    check("arst_locked", locked, 0);
    check("arst_err", err, 0);
    check("arst_state", dbgState, 0);
    waitClk(3);
    globalRest = 1'b0;
    errBase    = errCount;
    validBase  = validCycles;
    lineSeg(1'b1, 60);
    check("post_rst_no_err", errCount - errBase, 0);
    check("post_rst_no_valid", validCycles - validBase, 0);
    check("post_rst_unlocked", locked, 0);
    check("post_rst_hunt", dbgState, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/manchester_rx_ctrl.md
Name: manchester_rx_ctrl

Overview:
Frame-level receive controller for the Manchester decoder path. It takes the recovered line signal reCLK and times the interval between edges against the half-bit reference REF. A state machine hunts for the preamble, locks on the start-of-frame, and decodes bits by tracking bit phase. Decoded bits are packed into bytes and handed to the downstream register block through a valid/ready handshake.

Parameters:
CNT_W, 6, width of the edge-interval counter; the counter saturates at 2^CNT_W-1.
PREAMBLE_LEN, 8, minimum number of consecutive SHORT intervals required before lock.
DATA_BITS, 8, number of bits per output word.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
globalRest  input  1  asynchronous, active-high reset.
enable  input  1  receiver enable; low forces IDLE.
REF  input  4  half-bit period in clk cycles; legal values 4..15; changed only while enable=0.
reCLK  input  1  recovered Manchester line, asynchronous to clk.
rx_data  output  DATA_BITS  decoded word, LSB received first.
rx_valid  output  1  rx_data is valid; held until accepted.
rx_ready  input  1  downstream accepts the word when rx_valid=1 and rx_ready=1.
locked  output  1  high in DATA state.
err  output  1  one-cycle pulse on decode error or overrun.

Behaviour:
- Reset: rx_data=0, rx_valid=0, locked=0, err=0, state=IDLE, all counters 0.
- Input path: 2-flop synchronizer on reCLK, then a third flop.
  - edge = s2^s3; dir = s2 (1 = rising edge).
  - Edge detection latency is 3 clk from the line transition.
- Interval counter cnt:
  - On an edge cycle, iv=cnt+1 and cnt<=0.
  - Otherwise cnt increments, saturating at the maximum.
- Classification uses H=REF; compare 2*iv against multiples of H, with no division.
  - SHORT: H <= 2*iv < 3H.
  - LONG: 3H <= 2*iv < 5H.
  - BAD: anything else.
- Timeout: fires once when 2*cnt reaches 5H with no edge; it is treated as a BAD event at that cycle.
- States:
  - IDLE:
    - Entered when enable=0; entry is synchronous.
    - Clears run count, bit count, shift register and phase.
    - Goes to HUNT when enable=1.
  - HUNT:
    - run increments on SHORT, saturating at PREAMBLE_LEN.
    - BAD or timeout clears run.
    - LONG with run<PREAMBLE_LEN clears run.
    - LONG with run==PREAMBLE_LEN is start-of-frame: shift in bit=dir, phase p<=1 (mid-bit), bitcnt<=1, go to DATA.
  - DATA:
    - SHORT: p<=~p; when the new p=1, shift in bit=dir.
    - LONG with p=1: shift in bit=dir, p stays 1.
    - LONG with p=0: error.
    - BAD or timeout with bitcnt==0: end of frame, go to HUNT, no err.
    - BAD or timeout with bitcnt!=0: err pulse, partial word discarded, go to HUNT.
    - Error handling: err pulse, go to HUNT, run=0.
- Word completion:
  - When bitcnt reaches DATA_BITS, the shift register is moved to rx_data, rx_valid<=1, bitcnt<=0.
  - This happens in the same cycle as the final bit edge; rx_valid is seen the next clk.
- Handshake:
  - rx_valid clears on the cycle after rx_valid&rx_ready.
  - If a word completes while rx_valid=1 and rx_ready=0: overrun; the new word is dropped, rx_data is unchanged, err pulses, decoding continues.
  - If a word completes in the same cycle as an accept: the new word loads and rx_valid stays 1.
- enable low: overrides all state activity. rx_valid/rx_data are retained until accepted.
- Reset mid-frame: immediate return to reset values; no stale word or err after release.
- locked = (state==DATA), registered.

Test Plan:
All scenarios use REF=8, so SHORT is iv 4..11, LONG is iv 12..19, and timeout occurs at cnt=20.
1. Nominal frame:
   - Stimulus: 8 SHORT intervals of 8 clk, then LONG 16 clk, then Manchester-coded 0xA5 with rx_ready=1.
   - Response: locked rises after SOF; rx_valid one cycle with rx_data=0xA5; err never asserts.
2. Short preamble:
   - Stimulus: 7 SHORT intervals, then LONG.
   - Response: locked stays 0; no rx_valid.
3. Mid-word error:
   - Stimulus: after lock and 3 data bits, one interval of 3 clk.
   - Response: err one-cycle pulse; locked falls; no rx_valid.
   - Follow-up: a fresh preamble+0x3C decodes correctly.
4. Overrun:
   - Stimulus: two back-to-back words 0x11, 0x22 with rx_ready=0.
   - Response: rx_data=0x11 held; err pulses at the second completion.
   - Follow-up: rx_ready=1 for one cycle clears rx_valid.
5. End of frame and reset:
   - Stimulus: line idle for 25 clk after a complete word.
   - Response: HUNT with no err.
   - Stimulus: globalRest pulse mid-word.
   - Response: all outputs 0 asynchronously; no output activity until a new preamble.
